// File: rtl/rrv64_core_vec_param_pkg.sv
// Vector-core parameters shared by the register-file write-back path.
package rrv64_core_vec_param_pkg;

  localparam int ISA_VREG_WIDTH = 5;
  localparam int BANK_X_WIDTH   = 2;
  localparam int BANK_ROW_SIZE  = 64;

  // Row address is {vreg, bank}; the bank id sits in the low bits.
  localparam int VRF_ADDR_W     = ISA_VREG_WIDTH + BANK_X_WIDTH;
  localparam int VRF_DATA_W     = BANK_ROW_SIZE;
  localparam int VRF_BANK_SEL_W = BANK_X_WIDTH;

  typedef struct packed {
    logic [VRF_ADDR_W-1:0] addr;
    logic [VRF_DATA_W-1:0] data;
  } vrf_wb_entry_t;

endpackage

// File: rtl/vrf_wb_pair_sel.sv
// Decides whether the second-oldest queued result may retire alongside the
// oldest one on regfile write port 2.
module vrf_wb_pair_sel
  import rrv64_core_vec_param_pkg::*;
#(
  parameter int ADDR_W     = VRF_ADDR_W,
  parameter int BANK_SEL_W = VRF_BANK_SEL_W,
  parameter int CNT_W      = 4
) (
  input  logic [ADDR_W-1:0] i_head_addr,
  input  logic [ADDR_W-1:0] i_next_addr,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_wr1_ready,
  output logic              o_wr2_vld,
  output logic              o_bank_conflict
);

  logic w_same_row;
  logic w_two_queued;

  // Pair is issuable only when two entries exist, port 1 is moving, and the
  // entries hit different banks and different rows.
  always_comb begin
    o_bank_conflict = (i_head_addr[BANK_SEL_W-1:0] == i_next_addr[BANK_SEL_W-1:0]);
    w_same_row      = (i_head_addr == i_next_addr);
    w_two_queued    = (i_count >= CNT_W'(2));
    o_wr2_vld       = w_two_queued & i_wr1_ready & ~o_bank_conflict & ~w_same_row;
  end

endmodule

// File: rtl/vrf_wb_queue.sv
// Write-back queue: takes up to two FU results per cycle into a circular
// FIFO and drains them in order onto the two regfile write ports.
module vrf_wb_queue
  import rrv64_core_vec_param_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = VRF_ADDR_W,
  parameter int DATA_W     = VRF_DATA_W,
  parameter int BANK_SEL_W = VRF_BANK_SEL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in0_vld,
  output logic                       in0_ready,
  input  logic [ADDR_W-1:0]          in0_addr,
  input  logic [DATA_W-1:0]          in0_data,
  input  logic                       in1_vld,
  output logic                       in1_ready,
  input  logic [ADDR_W-1:0]          in1_addr,
  input  logic [DATA_W-1:0]          in1_data,
  output logic                       wr1_vld,
  input  logic                       wr1_ready,
  output logic [ADDR_W-1:0]          waddr1,
  output logic [DATA_W-1:0]          wdata1,
  output logic                       wr2_vld,
  input  logic                       wr2_ready,
  output logic [ADDR_W-1:0]          waddr2,
  output logic [DATA_W-1:0]          wdata2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is deliberately not reset; occupancy is tracked by pointers/count.
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [PTR_W-1:0]  w_head_nxt;
  logic [PTR_W-1:0]  w_in1_slot;
  logic              w_in0_fire;
  logic              w_in1_fire;
  logic              w_wr1_fire;
  logic              w_wr2_fire;
  logic              w_wr2_vld;
  logic              w_bank_conflict;
  logic [1:0]        w_enq_num;
  logic [1:0]        w_deq_num;

  assign w_head_nxt = r_head + PTR_W'(1);

  // Readiness looks only at occupancy so it never depends on this cycle's
  // valids or dequeues.
  assign in0_ready = (r_count < CNT_W'(DEPTH));
  assign in1_ready = (r_count < CNT_W'(DEPTH - 1));

  assign w_in0_fire = in0_vld & in0_ready;
  assign w_in1_fire = in1_vld & in1_ready;
  assign w_in1_slot = w_in0_fire ? (r_tail + PTR_W'(1)) : r_tail;
  assign w_enq_num  = {1'b0, w_in0_fire} + {1'b0, w_in1_fire};

  vrf_wb_pair_sel #(
    .ADDR_W     (ADDR_W),
    .BANK_SEL_W (BANK_SEL_W),
    .CNT_W      (CNT_W)
  ) u_pair_sel (
    .i_head_addr     (r_mem_addr[r_head]),
    .i_next_addr     (r_mem_addr[w_head_nxt]),
    .i_count         (r_count),
    .i_wr1_ready     (wr1_ready),
    .o_wr2_vld       (w_wr2_vld),
    .o_bank_conflict (w_bank_conflict)
  );

  assign wr1_vld = (r_count != '0);
  assign waddr1  = r_mem_addr[r_head];
  assign wdata1  = r_mem_data[r_head];
  assign wr2_vld = w_wr2_vld;
  assign waddr2  = r_mem_addr[w_head_nxt];
  assign wdata2  = r_mem_data[w_head_nxt];

  // Port 2 can only retire together with port 1; a same-bank pair is never
  // allowed to retire in one cycle.
  assign w_wr1_fire = wr1_vld & wr1_ready;
  assign w_wr2_fire = w_wr2_vld & wr2_ready & w_wr1_fire & ~w_bank_conflict;
  assign w_deq_num  = {1'b0, w_wr1_fire} + {1'b0, w_wr2_fire};

  assign count = r_count;
  assign empty = (r_count == '0);

  // Write accepted results into their slots; in0 always lands first.
  always_ff @(posedge clk) begin
    if (w_in0_fire) begin
      r_mem_addr[r_tail] <= in0_addr;
      r_mem_data[r_tail] <= in0_data;
    end
    if (w_in1_fire) begin
      r_mem_addr[w_in1_slot] <= in1_addr;
      r_mem_data[w_in1_slot] <= in1_data;
    end
  end

  // Advance pointers and occupancy; reset drops every queued entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq_num);
      r_tail  <= r_tail + PTR_W'(w_enq_num);
      r_count <= r_count + CNT_W'(w_enq_num) - CNT_W'(w_deq_num);
    end
  end

endmodule

// File: tb/tb_vrf_wb_queue.sv
// Directed bench for vrf_wb_queue (DEPTH=8, 7-bit rows, 64-bit data).
module tb_vrf_wb_queue;

  logic        clk;
  logic        rst;
  logic        in0_vld, in0_ready, in1_vld, in1_ready;
  logic [6:0]  in0_addr, in1_addr;
  logic [63:0] in0_data, in1_data;
  logic        wr1_vld, wr1_ready, wr2_vld, wr2_ready;
  logic [6:0]  waddr1, waddr2;
  logic [63:0] wdata1, wdata2;
  logic [3:0]  count;
  logic        empty;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0]  q_addr[$];
  logic [63:0] q_data[$];
  int          ecnt;
  logic        acc0, pop;

  vrf_wb_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in0_vld(in0_vld), .in0_ready(in0_ready), .in0_addr(in0_addr), .in0_data(in0_data),
    .in1_vld(in1_vld), .in1_ready(in1_ready), .in1_addr(in1_addr), .in1_data(in1_data),
    .wr1_vld(wr1_vld), .wr1_ready(wr1_ready), .waddr1(waddr1), .wdata1(wdata1),
    .wr2_vld(wr2_vld), .wr2_ready(wr2_ready), .waddr2(waddr2), .wdata2(wdata2),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic v0, input logic [6:0] a0, input logic [63:0] d0,
                     input logic v1, input logic [6:0] a1, input logic [63:0] d1);
    in0_vld = v0; in0_addr = a0; in0_data = d0;
    in1_vld = v1; in1_addr = a1; in1_data = d1;
    tick();
    in0_vld = 1'b0;
    in1_vld = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in0_vld = 1'b0; in1_vld = 1'b0;
    in0_addr = '0; in1_addr = '0; in0_data = '0; in1_data = '0;
    wr1_ready = 1'b0; wr2_ready = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wr1_vld", 64'(wr1_vld), 64'd0);
    chk("rst_wr2_vld", 64'(wr2_vld), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_in0_ready", 64'(in0_ready), 64'd1);
    chk("rst_in1_ready", 64'(in1_ready), 64'd1);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // dual enqueue, dual drain
    wr1_ready = 1'b1; wr2_ready = 1'b1;
    enq(1'b1, 7'h10, 64'hA0, 1'b1, 7'h11, 64'hA1);
    chk("dual_wr1_vld", 64'(wr1_vld), 64'd1);
    chk("dual_waddr1", 64'(waddr1), 64'h10);
    chk("dual_wdata1", wdata1, 64'hA0);
    chk("dual_wr2_vld", 64'(wr2_vld), 64'd1);
    chk("dual_waddr2", 64'(waddr2), 64'h11);
    chk("dual_wdata2", wdata2, 64'hA1);
    chk("dual_count", 64'(count), 64'd2);
    tick();
    chk("dual_empty", 64'(empty), 64'd1);

    // bank conflict: 0x20 and 0x24 share bank 0
    enq(1'b1, 7'h20, 64'hB0, 1'b1, 7'h24, 64'hB4);
    chk("bank_c1_wr1_vld", 64'(wr1_vld), 64'd1);
    chk("bank_c1_waddr1", 64'(waddr1), 64'h20);
    chk("bank_c1_wr2_vld", 64'(wr2_vld), 64'd0);
    tick();
    chk("bank_c2_wr1_vld", 64'(wr1_vld), 64'd1);
    chk("bank_c2_waddr1", 64'(waddr1), 64'h24);
    chk("bank_c2_wr2_vld", 64'(wr2_vld), 64'd0);
    chk("bank_c2_count", 64'(count), 64'd1);
    tick();
    chk("bank_empty", 64'(empty), 64'd1);

    // same-row WAW
    enq(1'b1, 7'h30, 64'hAAAA, 1'b1, 7'h30, 64'hBBBB);
    chk("waw_c1_wdata1", wdata1, 64'hAAAA);
    chk("waw_c1_wr2_vld", 64'(wr2_vld), 64'd0);
    tick();
    chk("waw_c2_wr1_vld", 64'(wr1_vld), 64'd1);
    chk("waw_c2_wdata1", wdata1, 64'hBBBB);
    chk("waw_c2_wr2_vld", 64'(wr2_vld), 64'd0);
    tick();
    chk("waw_empty", 64'(empty), 64'd1);

    // full boundary with both ports stalled
    wr1_ready = 1'b0; wr2_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      enq(1'b1, 7'(8'h50 + 2 * k), 64'hF000 + 64'(2 * k),
          1'b1, 7'(8'h51 + 2 * k), 64'hF001 + 64'(2 * k));
      q_addr.push_back(7'(8'h50 + 2 * k)); q_data.push_back(64'hF000 + 64'(2 * k));
      q_addr.push_back(7'(8'h51 + 2 * k)); q_data.push_back(64'hF001 + 64'(2 * k));
    end
    enq(1'b1, 7'h56, 64'hF006, 1'b0, 7'h00, 64'h0);
    q_addr.push_back(7'h56); q_data.push_back(64'hF006);
    chk("full7_count", 64'(count), 64'd7);
    chk("full7_in0_ready", 64'(in0_ready), 64'd1);
    chk("full7_in1_ready", 64'(in1_ready), 64'd0);
    // pair offered at 7: only in0 fits
    enq(1'b1, 7'h57, 64'hF007, 1'b1, 7'h58, 64'hF008);
    q_addr.push_back(7'h57); q_data.push_back(64'hF007);
    chk("full8_count", 64'(count), 64'd8);
    chk("full8_in0_ready", 64'(in0_ready), 64'd0);
    chk("full8_in1_ready", 64'(in1_ready), 64'd0);
    chk("full8_waddr1", 64'(waddr1), 64'h50);
    enq(1'b1, 7'h59, 64'hF009, 1'b1, 7'h5A, 64'hF00A);
    chk("full8_hold_count", 64'(count), 64'd8);

    // release port 1 and stream through several laps
    ecnt = 8;
    wr1_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in0_vld  = (cyc < 22);
      in0_addr = 7'(8'h60 + cyc);
      in0_data = 64'hC000 + 64'(cyc);
      #1;
      chk("lap_count", 64'(count), 64'(ecnt));
      chk("lap_wr1_vld", 64'(wr1_vld), 64'(ecnt > 0));
      if (ecnt > 0) begin
        chk("lap_waddr1", 64'(waddr1), 64'(q_addr[0]));
        chk("lap_wdata1", wdata1, q_data[0]);
      end
      acc0 = in0_vld && (ecnt < 8);
      pop  = (ecnt > 0);
      tick();
      if (pop) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (acc0) begin
        q_addr.push_back(7'(8'h60 + cyc));
        q_data.push_back(64'hC000 + 64'(cyc));
      end
      ecnt = ecnt + int'(acc0) - int'(pop);
    end
    in0_vld = 1'b0;
    for (int cyc = 0; cyc < 16 && ecnt > 0; cyc++) begin
      #1;
      chk("drain_count", 64'(count), 64'(ecnt));
      chk("drain_waddr1", 64'(waddr1), 64'(q_addr[0]));
      chk("drain_wdata1", wdata1, q_data[0]);
      tick();
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
      ecnt--;
    end
    #1;
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_model_empty", 64'(ecnt), 64'd0);

    // port-1 stall with three entries queued
    wr1_ready = 1'b0; wr2_ready = 1'b1;
    enq(1'b1, 7'h40, 64'hE0, 1'b1, 7'h41, 64'hE1);
    enq(1'b1, 7'h42, 64'hE2, 1'b0, 7'h00, 64'h0);
    for (int k = 0; k < 4; k++) begin
      chk("stall_wr2_vld", 64'(wr2_vld), 64'd0);
      chk("stall_waddr1", 64'(waddr1), 64'h40);
      chk("stall_count", 64'(count), 64'd3);
      tick();
    end
    wr1_ready = 1'b1;
    #1;
    chk("rel_wr1_vld", 64'(wr1_vld), 64'd1);
    chk("rel_waddr1", 64'(waddr1), 64'h40);
    chk("rel_wr2_vld", 64'(wr2_vld), 64'd1);
    chk("rel_waddr2", 64'(waddr2), 64'h41);
    tick();
    chk("rel2_waddr1", 64'(waddr1), 64'h42);
    chk("rel2_wdata1", wdata1, 64'hE2);
    chk("rel2_wr2_vld", 64'(wr2_vld), 64'd0);
    chk("rel2_count", 64'(count), 64'd1);
    tick();
    chk("rel_empty", 64'(empty), 64'd1);

    // reset mid-stream with five entries queued
    wr1_ready = 1'b0; wr2_ready = 1'b0;
    enq(1'b1, 7'h01, 64'h1, 1'b1, 7'h02, 64'h2);
    enq(1'b1, 7'h03, 64'h3, 1'b1, 7'h04, 64'h4);
    enq(1'b1, 7'h05, 64'h5, 1'b0, 7'h00, 64'h0);
    chk("pre_rst_count", 64'(count), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_wr1_vld", 64'(wr1_vld), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_in0_ready", 64'(in0_ready), 64'd1);
    chk("mid_rst_in1_ready", 64'(in1_ready), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_empty", 64'(empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
